// File: rtl/config_loader.sv
// config_loader: buffers a host firmware byte string for one instrumentation
// block, pauses tracing, drains the pipeline, and then streams the bytes on the
// shared configId/configData bus as one unbroken burst. Tracing resumes after
// the burst.
// The optional burst checksum is built only when CFG_LOADER_CHECKSUM_EN is defined.
// Otherwise cfg_checksum is tied to zero.
module config_loader #(
  parameter int         MAX_BYTES    = 16,
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [7:0] IDLE_ID      = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trace_en_in,
  input  logic       cfg_start,
  input  logic [7:0] cfg_block_id,
  input  logic [7:0] cfg_len,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       busy,
  output logic       done,
  output logic       cfg_err,
  output logic [7:0] cfg_checksum,
  output logic       tracing_out,
  output logic [7:0] configId,
  output logic [7:0] configData
);

  // Buffer address width, and pointer/length width (pointers must reach MAX_BYTES).
  localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW-1:0] ADDR0 = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_STREAM,
    ST_GAP
  } state_t;

  state_t        state_q;
  logic [7:0]    id_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] wr_ptr_q;
  logic [LW-1:0] rd_ptr_q;
  logic [DW-1:0] drain_cnt_q;
  logic          byte_ready_q;
  logic          busy_q;
  logic          done_q;
  logic          cfg_err_q;
  logic          tracing_q;
  logic [7:0]    config_id_q;
  logic [7:0]    config_data_q;

  logic [7:0]    buf_mem [MAX_BYTES];

  logic          req_ok;
  logic          byte_take;
  logic          drain_last;

  // A request is rejected when empty, oversized, or aimed at the idle ID.
  assign req_ok     = (cfg_len != 8'd0) && (cfg_len <= 8'(MAX_BYTES)) &&
                      (cfg_block_id != IDLE_ID);
  assign byte_take  = (state_q == ST_LOAD) && byte_valid && byte_ready_q;
  assign drain_last = (state_q == ST_DRAIN) && (drain_cnt_q == DW'(DRAIN_CYCLES - 1));

  // Byte buffer write port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (byte_take) begin
      buf_mem[wr_ptr_q[AW-1:0]] <= byte_data;
    end
  end

  // Main sequencer: all bus, handshake and status outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      id_q          <= IDLE_ID;
      len_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      drain_cnt_q   <= '0;
      byte_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      tracing_q     <= 1'b0;
      config_id_q   <= IDLE_ID;
      config_data_q <= '0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tracing_q     <= trace_en_in;
          config_id_q   <= IDLE_ID;
          config_data_q <= '0;
          if (cfg_start) begin
            if (req_ok) begin
              state_q      <= ST_LOAD;
              id_q         <= cfg_block_id;
              len_q        <= cfg_len[LW-1:0];
              wr_ptr_q     <= '0;
              byte_ready_q <= 1'b1;
              busy_q       <= 1'b1;
            end else begin
              done_q    <= 1'b1;
              cfg_err_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          tracing_q <= trace_en_in;
          if (byte_take) begin
            wr_ptr_q <= wr_ptr_q + LW'(1);
            // Last byte: stop accepting and pause tracing on the same edge.
            if (wr_ptr_q == len_q - LW'(1)) begin
              byte_ready_q <= 1'b0;
              tracing_q    <= 1'b0;
              drain_cnt_q  <= '0;
              state_q      <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          tracing_q <= 1'b0;
          if (drain_last) begin
            // First burst byte goes out together with the target ID.
            state_q       <= ST_STREAM;
            config_id_q   <= id_q;
            config_data_q <= buf_mem[ADDR0];
            rd_ptr_q      <= LW'(1);
          end else begin
            drain_cnt_q <= drain_cnt_q + DW'(1);
          end
        end

        ST_STREAM: begin
          if (rd_ptr_q == len_q) begin
            state_q       <= ST_GAP;
            config_id_q   <= IDLE_ID;
            config_data_q <= '0;
          end else begin
            config_data_q <= buf_mem[rd_ptr_q[AW-1:0]];
            rd_ptr_q      <= rd_ptr_q + LW'(1);
          end
        end

        ST_GAP: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          tracing_q <= trace_en_in;
        end

        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          byte_ready_q <= 1'b0;
          config_id_q  <= IDLE_ID;
        end
      endcase
    end
  end

`ifdef CFG_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q;

  // Sum of every byte on the bus during STREAM; cleared as STREAM is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (drain_last) begin
      checksum_q <= '0;
    end else if (state_q == ST_STREAM) begin
      checksum_q <= checksum_q + config_data_q;
    end
  end

  assign cfg_checksum = checksum_q;
`else
  assign cfg_checksum = '0;
`endif

  assign byte_ready  = byte_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign tracing_out = tracing_q;
  assign configId    = config_id_q;
  assign configData  = config_data_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader with DRAIN_CYCLES=3, MAX_BYTES=16.
module tb_config_loader;
  localparam int DRAIN = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       trace_en_in;
  logic       cfg_start;
  logic [7:0] cfg_block_id;
  logic [7:0] cfg_len;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic [7:0] cfg_checksum;
  logic       tracing_out;
  logic [7:0] configId;
  logic [7:0] configData;

  int n_tests = 0;
  int n_fail  = 0;

  config_loader #(
    .MAX_BYTES   (16),
    .DRAIN_CYCLES(DRAIN),
    .IDLE_ID     (8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trace_en_in (trace_en_in),
    .cfg_start   (cfg_start),
    .cfg_block_id(cfg_block_id),
    .cfg_len     (cfg_len),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .cfg_checksum(cfg_checksum),
    .tracing_out (tracing_out),
    .configId    (configId),
    .configData  (configData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [7:0] id;
    logic [7:0] len;
    logic       bv;
    logic [7:0] bd;
    logic       rdy;
    logic       bsy;
    logic       dn;
    logic       er;
    logic       trc;
    logic [7:0] cid;
    logic [7:0] cdat;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic st, input logic [7:0] id, input logic [7:0] len,
                     input logic bv, input logic [7:0] bd, input logic rdy,
                     input logic bsy, input logic dn, input logic er, input logic trc,
                     input logic [7:0] cid, input logic [7:0] cdat);
    vec_t v;
    v.st = st; v.id = id; v.len = len; v.bv = bv; v.bd = bd;
    v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.er = er; v.trc = trc;
    v.cid = cid; v.cdat = cdat;
    tv.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Issue a start and feed len bytes, optionally with byte_valid gaps.
  task automatic do_request(input logic [7:0] id, input int len,
                            input logic [7:0] bytes [16], input logic toggle,
                            input logic check_trace);
    int   i;
    int   cyc;
    logic rdy;
    cfg_start    = 1'b1;
    cfg_block_id = id;
    cfg_len      = 8'(len);
    tick();
    cfg_start = 1'b0;
    chk1("req_busy", busy, 1'b1);
    i   = 0;
    cyc = 0;
    while (i < len && cyc < 100) begin
      byte_valid = toggle ? ((cyc % 2 == 0) ? 1'b1 : 1'b0) : 1'b1;
      byte_data  = bytes[i];
      rdy        = byte_ready;
      tick();
      cyc++;
      if (byte_valid && rdy) i++;
      if (check_trace) chk1("trace_load", tracing_out, (i < len) ? 1'b1 : 1'b0);
    end
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    if (i < len) begin
      n_tests++;
      n_fail++;
      $display("FAIL load_timeout: got %0d bytes expected %0d", i, len);
    end
    $display("[TB] request id=%02h len=%0d loaded", id, len);
  endtask

  // Wait for the burst, check it is contiguous, then the gap and done.
  task automatic expect_burst(input logic [7:0] id, input int len,
                              input logic [7:0] bytes [16]);
    int w = 0;
    while (configId === 8'hFF && w < 20) begin
      chk1("trace_paused", tracing_out, 1'b0);
      tick();
      w++;
    end
    if (w >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL burst_timeout: got configId %02h expected %02h", configId, id);
    end
    for (int j = 0; j < len; j++) begin
      chk8($sformatf("burst_id%0d", j), configId, id);
      chk8($sformatf("burst_data%0d", j), configData, bytes[j]);
      chk1($sformatf("burst_trace%0d", j), tracing_out, 1'b0);
      tick();
    end
    chk8("gap_id", configId, 8'hFF);
    chk8("gap_data", configData, 8'h00);
    chk1("gap_done", done, 1'b0);
    tick();
    chk1("end_done", done, 1'b1);
    chk1("end_err", cfg_err, 1'b0);
    chk1("end_busy", busy, 1'b0);
    chk1("end_trace", tracing_out, trace_en_in);
    $display("[TB] burst id=%02h len=%0d completed", id, len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b_a [16];
    logic [7:0] b_b [16];
    logic [7:0] b_c [16];
    logic [7:0] exp_sum;
    int         w;

    foreach (b_a[k]) begin
      b_a[k] = 8'h00;
      b_b[k] = 8'h00;
      b_c[k] = 8'h00;
    end
    b_a[0] = 8'h11; b_a[1] = 8'h22; b_a[2] = 8'h33; b_a[3] = 8'h44;
    b_b[0] = 8'h01; b_b[1] = 8'h02;
    b_c[0] = 8'h80; b_c[1] = 8'h90;

    reset        = 1'b1;
    trace_en_in  = 1'b1;
    cfg_start    = 1'b0;
    cfg_block_id = 8'h00;
    cfg_len      = 8'h00;
    byte_valid   = 1'b0;
    byte_data    = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_ready", byte_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", cfg_err, 1'b0);
    chk8("rst_sum", cfg_checksum, 8'h00);
    chk1("rst_trace", tracing_out, 1'b0);
    chk8("rst_id", configId, 8'hFF);
    chk8("rst_data", configData, 8'h00);
    reset = 1'b0;

    // Basic burst: id 2, len 4, back-to-back bytes, then three rejected requests.
    //   st id     len    bv bd     rdy bsy dn er trc cid    cdat
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  0,  0, 0, 1,  8'hFF, 8'h00);
    add(1, 8'h02, 8'd4,  0, 8'h00, 1,  1,  0, 0, 1,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  1, 8'h11, 1,  1,  0, 0, 1,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  1, 8'h22, 1,  1,  0, 0, 1,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  1, 8'h33, 1,  1,  0, 0, 1,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  1, 8'h44, 0,  1,  0, 0, 0,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  1,  0, 0, 0,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  1,  0, 0, 0,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  1,  0, 0, 0,  8'h02, 8'h11);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  1,  0, 0, 0,  8'h02, 8'h22);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  1,  0, 0, 0,  8'h02, 8'h33);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  1,  0, 0, 0,  8'h02, 8'h44);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  1,  0, 0, 0,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  0,  1, 0, 1,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  0,  0, 0, 1,  8'hFF, 8'h00);
    add(1, 8'h03, 8'd0,  0, 8'h00, 0,  0,  1, 1, 1,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  0,  0, 0, 1,  8'hFF, 8'h00);
    add(1, 8'h03, 8'd17, 0, 8'h00, 0,  0,  1, 1, 1,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  0,  0, 0, 1,  8'hFF, 8'h00);
    add(1, 8'hFF, 8'd4,  0, 8'h00, 0,  0,  1, 1, 1,  8'hFF, 8'h00);
    add(0, 8'h00, 8'd0,  0, 8'h00, 0,  0,  0, 0, 1,  8'hFF, 8'h00);

    for (int k = 0; k < tv.size(); k++) begin
      cfg_start    = tv[k].st;
      cfg_block_id = tv[k].id;
      cfg_len      = tv[k].len;
      byte_valid   = tv[k].bv;
      byte_data    = tv[k].bd;
      tick();
      chk1($sformatf("v%0d.ready", k), byte_ready, tv[k].rdy);
      chk1($sformatf("v%0d.busy", k), busy, tv[k].bsy);
      chk1($sformatf("v%0d.done", k), done, tv[k].dn);
      chk1($sformatf("v%0d.err", k), cfg_err, tv[k].er);
      chk1($sformatf("v%0d.trace", k), tracing_out, tv[k].trc);
      chk8($sformatf("v%0d.id", k), configId, tv[k].cid);
      chk8($sformatf("v%0d.data", k), configData, tv[k].cdat);
      $display("[TB] vec %0d start=%0b id=%02h len=%0d bv=%0b bd=%02h -> cid=%02h cdat=%02h",
               k, tv[k].st, tv[k].id, tv[k].len, tv[k].bv, tv[k].bd, configId, configData);
    end
    cfg_start  = 1'b0;
    byte_valid = 1'b0;

`ifdef CFG_LOADER_CHECKSUM_EN
    exp_sum = 8'hAA;
`else
    exp_sum = 8'h00;
`endif
    chk8("sum_basic", cfg_checksum, exp_sum);

    // Same request with byte_valid gaps during LOAD.
    do_request(8'h02, 4, b_a, 1'b1, 1'b1);
    expect_burst(8'h02, 4, b_a);

    // cfg_start during DRAIN must be ignored.
    do_request(8'h02, 2, b_b, 1'b0, 1'b0);
    cfg_start    = 1'b1;
    cfg_block_id = 8'h05;
    cfg_len      = 8'd2;
    tick();
    cfg_start = 1'b0;
    chk1("drain_start_busy", busy, 1'b1);
    chk1("drain_start_done", done, 1'b0);
    expect_burst(8'h02, 2, b_b);
`ifdef CFG_LOADER_CHECKSUM_EN
    exp_sum = 8'h03;
`else
    exp_sum = 8'h00;
`endif
    chk8("sum_ignored", cfg_checksum, exp_sum);

    // Asynchronous reset on the second STREAM cycle.
    do_request(8'h02, 4, b_a, 1'b0, 1'b0);
    w = 0;
    while (configId !== 8'h02 && w < 20) begin
      tick();
      w++;
    end
    chk8("rst_mid_first", configData, 8'h11);
    tick();
    chk8("rst_mid_second", configData, 8'h22);
    #2;
    reset = 1'b1;
    #1;
    chk8("rst_mid_id", configId, 8'hFF);
    chk1("rst_mid_trace", tracing_out, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk8("rst_mid_data", configData, 8'h00);
    chk8("rst_mid_sum", cfg_checksum, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk1("rst_mid_nodone", done, 1'b0);
      chk8("rst_mid_idle", configId, 8'hFF);
    end
    $display("[TB] mid-burst reset handled");

    // Request after reset, with checksum wrap: 80 + 90 = 10 mod 256.
    do_request(8'h07, 2, b_c, 1'b0, 1'b0);
    expect_burst(8'h07, 2, b_c);
`ifdef CFG_LOADER_CHECKSUM_EN
    exp_sum = 8'h10;
`else
    exp_sum = 8'h00;
`endif
    chk8("sum_wrap", cfg_checksum, exp_sum);
    tick();
    chk8("sum_hold", cfg_checksum, exp_sum);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
